// File: rtl/pe_act_broadcast_fsm_pkg.sv
// Shared types and defaults for the PE activation broadcast producer.
// Also holds the FIFO credit helper.
package pe_act_broadcast_fsm_pkg;

  localparam int PE_NUM_LOG_D = 6;
  localparam int DATA_W_D     = 16;
  localparam int ADDR_W_D     = 16;
  localparam int ACT_NO_W_D   = 10;
  localparam int LAYER_W_D    = 4;
  localparam int FIFO_DEPTH   = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BCAST = 2'd1,
    ST_SYNC  = 2'd2
  } bcast_st_e;

  // Occupancy once the in-flight read lands must stay within the FIFO.
  function automatic logic credit_ok(
    input logic [1:0] cnt,
    input logic       pop,
    input logic       inflight
  );
    logic [2:0] occ;
    occ = {1'b0, cnt}
        - {2'b00, pop}
        + {2'b00, inflight};
    return occ < 3'(FIFO_DEPTH);
  endfunction

endpackage

// File: rtl/pe_act_broadcast_fsm_if.sv
// Broadcast injection port handshake.
// Transfer happens when bcast_valid & bcast_ready.
interface pe_act_broadcast_fsm_if
  import pe_act_broadcast_fsm_pkg::*;
#(
  parameter int DATA_W = DATA_W_D,
  parameter int ADDR_W = ADDR_W_D
);

  logic                     bcast_valid;
  logic                     bcast_ready;
  logic [ADDR_W+DATA_W-1:0] bcast_data;

  modport master (
    output bcast_valid,
    output bcast_data,
    input  bcast_ready
  );

  modport slave (
    input  bcast_valid,
    input  bcast_data,
    output bcast_ready
  );

endinterface

// File: rtl/pe_act_broadcast_fsm_fifo2.sv
// Two-entry synchronous FIFO with occupancy count.
// Head reads as zero while empty.
module pe_act_broadcast_fsm_fifo2 #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic [1:0]   cnt,
  output logic         empty
);

  logic [W-1:0] mem [2];
  logic         wp;
  logic         rp;
  logic         do_push;
  logic         do_pop;

  assign empty   = (cnt == 2'd0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (cnt != 2'd2);
  assign rdata   = empty ? '0 : mem[rp];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wp     <= 1'b0;
      rp     <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wp] <= wdata;
        wp      <= ~wp;
      end
      if (do_pop) begin
        rp <= ~rp;
      end
      cnt <= cnt
           + {1'b0, do_push}
           - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/pe_act_broadcast_fsm.sv
// PE activation broadcast producer: streams nonzero local
// activations as {abs_idx, value} onto the injection port.
module pe_act_broadcast_fsm
  import pe_act_broadcast_fsm_pkg::*;
#(
  parameter int PE_IDX     = 0,
  parameter int PE_NUM_LOG = PE_NUM_LOG_D,
  parameter int DATA_W     = DATA_W_D,
  parameter int ADDR_W     = ADDR_W_D,
  parameter int ACT_NO_W   = ACT_NO_W_D,
  parameter int LAYER_W    = LAYER_W_D
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pe_start_bcast,
  input  logic [LAYER_W-1:0]  layer_no,
  input  logic [ACT_NO_W-1:0] in_act_no,
  input  logic                layer_done,
  output logic [LAYER_W-1:0]  layer_idx,
  output logic                act_rd_en,
  output logic [ACT_NO_W-1:0] act_rd_addr,
  input  logic [DATA_W-1:0]   act_rd_data,
  pe_act_broadcast_fsm_if.master bcast,
  output logic                fin_broadcast,
  output logic                busy
);

  localparam int AW = ACT_NO_W + PE_NUM_LOG;
  localparam int EW = ADDR_W + DATA_W;

  bcast_st_e           st;
  logic [ACT_NO_W-1:0] rd_ptr;
  logic [ACT_NO_W-1:0] rd_addr_q;
  logic                inflight;

  logic [AW-1:0]       abs_wide;
  logic [ADDR_W-1:0]   abs_idx;
  logic [1:0]          fifo_cnt;
  logic                fifo_empty;
  logic [EW-1:0]       fifo_head;
  logic                pop;
  logic                push;
  logic                rd_go;
  logic                done_cond;
  logic                last_layer;

  assign abs_wide = {rd_addr_q, {PE_NUM_LOG{1'b0}}}
                  + AW'(PE_IDX);
  assign abs_idx  = ADDR_W'(abs_wide);

  assign pop  = ~fifo_empty & bcast.bcast_ready;
  assign push = inflight & (act_rd_data != '0);

  assign rd_go = (st == ST_BCAST)
               & (rd_ptr < in_act_no)
               & credit_ok(fifo_cnt, pop, inflight);

  // Layer is complete only once nothing is left in the read pipe.
  assign done_cond = (st == ST_BCAST)
                   & (rd_ptr == in_act_no)
                   & ~inflight
                   & fifo_empty;

  assign last_layer = (layer_idx == layer_no - LAYER_W'(1));

  assign act_rd_en         = rd_go;
  assign act_rd_addr       = rd_go ? rd_ptr : '0;
  assign bcast.bcast_valid = ~fifo_empty;
  assign bcast.bcast_data  = fifo_head;
  assign busy              = (st != ST_IDLE);

  pe_act_broadcast_fsm_fifo2 #(
    .W (EW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata ({abs_idx, act_rd_data}),
    .pop   (pop),
    .rdata (fifo_head),
    .cnt   (fifo_cnt),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st            <= ST_IDLE;
      rd_ptr        <= '0;
      rd_addr_q     <= '0;
      inflight      <= 1'b0;
      layer_idx     <= '0;
      fin_broadcast <= 1'b0;
    end else begin
      fin_broadcast <= 1'b0;
      inflight      <= rd_go;
      if (rd_go) begin
        rd_addr_q <= rd_ptr;
        rd_ptr    <= rd_ptr + ACT_NO_W'(1);
      end
      unique case (st)
        ST_IDLE: begin
          if (pe_start_bcast) begin
            st        <= ST_BCAST;
            layer_idx <= '0;
            rd_ptr    <= '0;
          end
        end
        ST_BCAST: begin
          if (done_cond) begin
            fin_broadcast <= 1'b1;
            st            <= ST_SYNC;
          end
        end
        ST_SYNC: begin
          if (layer_done) begin
            if (last_layer) begin
              st <= ST_IDLE;
            end else begin
              layer_idx <= layer_idx + LAYER_W'(1);
              rd_ptr    <= '0;
              st        <= ST_BCAST;
            end
          end
        end
        default: st <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_act_broadcast_fsm.sv
// Directed bench for pe_act_broadcast_fsm with PE_IDX=5.
// SRAM model returns data one cycle after act_rd_en.
module tb_pe_act_broadcast_fsm;

  localparam int LW = 4;
  localparam int NW = 10;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          pe_start_bcast = 1'b0;
  logic [LW-1:0] layer_no = 4'd1;
  logic [NW-1:0] in_act_no = '0;
  logic          layer_done = 1'b0;
  logic [LW-1:0] layer_idx;
  logic          act_rd_en;
  logic [NW-1:0] act_rd_addr;
  logic [DW-1:0] act_rd_data;
  logic          fin_broadcast;
  logic          busy;

  pe_act_broadcast_fsm_if bif ();

  pe_act_broadcast_fsm #(
    .PE_IDX (5)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .pe_start_bcast (pe_start_bcast),
    .layer_no       (layer_no),
    .in_act_no      (in_act_no),
    .layer_done     (layer_done),
    .layer_idx      (layer_idx),
    .act_rd_en      (act_rd_en),
    .act_rd_addr    (act_rd_addr),
    .act_rd_data    (act_rd_data),
    .bcast          (bif.master),
    .fin_broadcast  (fin_broadcast),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [8];
  logic [31:0]   got_q [$];
  logic [31:0]   exp_q [$];
  int            n_vec = 0;
  int            n_bad = 0;
  int            fin_cnt = 0;
  int            rd_cnt = 0;
  int            stab_err = 0;
  int            coinc = 0;
  logic          prev_stall = 1'b0;
  logic [31:0]   prev_data = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) act_rd_data <= '0;
    else if (act_rd_en) act_rd_data <= mem[act_rd_addr[2:0]];
  end

  always @(posedge clk) begin
    if (!rst) begin
      if (bif.bcast_valid && bif.bcast_ready)
        got_q.push_back(bif.bcast_data);
      if (fin_broadcast) fin_cnt++;
      if (act_rd_en) rd_cnt++;
      if (fin_broadcast && bif.bcast_valid) coinc++;
      if (prev_stall &&
          (!bif.bcast_valid || bif.bcast_data != prev_data))
        stab_err++;
      prev_stall = bif.bcast_valid && !bif.bcast_ready;
      prev_data  = bif.bcast_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic chk_entries(input string tag);
    chk({tag, "_cnt"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size()) chk(tag, 64'(got_q[i]), 64'(exp_q[i]));
      else chk(tag, 64'hdead, 64'(exp_q[i]));
    end
  endtask

  task automatic clear_stats();
    got_q.delete();
    exp_q.delete();
    rd_cnt = 0;
    fin_cnt = 0;
    stab_err = 0;
    coinc = 0;
  endtask

  task automatic start();
    pe_start_bcast = 1'b1;
    @(negedge clk);
    pe_start_bcast = 1'b0;
  endtask

  task automatic done_pulse();
    layer_done = 1'b1;
    @(negedge clk);
    layer_done = 1'b0;
  endtask

  task automatic wait_fin(input int budget, input logic toggle);
    int i;
    for (i = 0; i < budget; i++) begin
      if (fin_broadcast) break;
      @(negedge clk);
      if (toggle) bif.bcast_ready = ~bif.bcast_ready;
    end
    if (i == budget) chk("fin_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    bif.bcast_ready = 1'b1;
    mem[0] = 16'd7; mem[1] = 16'd0; mem[2] = 16'd9;
    for (int i = 3; i < 8; i++) mem[i] = '0;

    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_valid", 64'(bif.bcast_valid), 64'd0);
    chk("rst_data", 64'(bif.bcast_data), 64'd0);
    chk("rst_rd_en", 64'(act_rd_en), 64'd0);
    chk("rst_layer", 64'(layer_idx), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // layer_done in IDLE is ignored
    done_pulse();
    chk("idle_done_ign", 64'(busy), 64'd0);

    // basic stream, ready=1
    clear_stats();
    in_act_no = 10'd3;
    start();
    chk("bc_busy", 64'(busy), 64'd1);
    chk("bc_rd_en0", 64'(act_rd_en), 64'd1);
    pe_start_bcast = 1'b1;
    @(negedge clk);
    pe_start_bcast = 1'b0;
    @(negedge clk);
    chk("bc_lat_valid", 64'(bif.bcast_valid), 64'd1);
    chk("bc_lat_data", 64'(bif.bcast_data), 64'h0005_0007);
    wait_fin(40, 1'b0);
    @(negedge clk);
    chk("bc_fin_1cyc", 64'(fin_broadcast), 64'd0);
    exp_q = '{32'h0005_0007, 32'h0085_0009};
    chk_entries("bc_entry");
    chk("bc_fin_cnt", 64'(fin_cnt), 64'd1);
    chk("bc_rd_cnt", 64'(rd_cnt), 64'd3);
    chk("bc_sync_busy", 64'(busy), 64'd1);
    done_pulse();
    chk("bc_idle", 64'(busy), 64'd0);

    // ready toggling 1010...
    clear_stats();
    start();
    wait_fin(60, 1'b1);
    @(negedge clk);
    bif.bcast_ready = 1'b1;
    exp_q = '{32'h0005_0007, 32'h0085_0009};
    chk_entries("tg_entry");
    chk("tg_stable", 64'(stab_err), 64'd0);
    chk("tg_coinc", 64'(coinc), 64'd0);
    done_pulse();

    // stall for 10 cycles with three nonzero values
    clear_stats();
    mem[1] = 16'd8;
    bif.bcast_ready = 1'b0;
    start();
    repeat (10) @(negedge clk);
    chk("st_rd_cnt", 64'(rd_cnt), 64'd2);
    chk("st_valid", 64'(bif.bcast_valid), 64'd1);
    chk("st_head", 64'(bif.bcast_data), 64'h0005_0007);
    chk("st_no_fin", 64'(fin_cnt), 64'd0);
    bif.bcast_ready = 1'b1;
    wait_fin(40, 1'b0);
    @(negedge clk);
    exp_q = '{32'h0005_0007, 32'h0045_0008, 32'h0085_0009};
    chk_entries("st_entry");
    chk("st_stable", 64'(stab_err), 64'd0);
    done_pulse();

    // empty layer
    clear_stats();
    in_act_no = 10'd0;
    start();
    chk("z_fin_early", 64'(fin_broadcast), 64'd0);
    @(negedge clk);
    chk("z_fin", 64'(fin_broadcast), 64'd1);
    chk("z_rd_cnt", 64'(rd_cnt), 64'd0);
    done_pulse();

    // all-zero layer
    clear_stats();
    mem[0] = '0; mem[1] = '0; mem[2] = '0;
    in_act_no = 10'd3;
    start();
    wait_fin(40, 1'b0);
    @(negedge clk);
    chk("az_rd_cnt", 64'(rd_cnt), 64'd3);
    chk("az_entries", 64'(got_q.size()), 64'd0);
    chk("az_fin_cnt", 64'(fin_cnt), 64'd1);
    done_pulse();

    // two layers
    clear_stats();
    mem[0] = 16'd7; mem[1] = 16'd0; mem[2] = 16'd9;
    layer_no = 4'd2;
    start();
    wait_fin(40, 1'b0);
    @(negedge clk);
    chk("ml_layer0", 64'(layer_idx), 64'd0);
    done_pulse();
    chk("ml_layer1", 64'(layer_idx), 64'd1);
    chk("ml_busy1", 64'(busy), 64'd1);
    wait_fin(40, 1'b0);
    @(negedge clk);
    exp_q = '{32'h0005_0007, 32'h0085_0009,
              32'h0005_0007, 32'h0085_0009};
    chk_entries("ml_entry");
    chk("ml_fin_cnt", 64'(fin_cnt), 64'd2);
    done_pulse();
    chk("ml_idle", 64'(busy), 64'd0);
    layer_no = 4'd1;

    // reset mid-stream with ready=0
    clear_stats();
    mem[1] = 16'd8;
    bif.bcast_ready = 1'b0;
    start();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("ar_valid", 64'(bif.bcast_valid), 64'd0);
    chk("ar_data", 64'(bif.bcast_data), 64'd0);
    chk("ar_busy", 64'(busy), 64'd0);
    chk("ar_rd_en", 64'(act_rd_en), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    bif.bcast_ready = 1'b1;
    @(negedge clk);
    chk("ar_no_fin", 64'(fin_cnt), 64'd0);
    clear_stats();
    start();
    wait_fin(40, 1'b0);
    @(negedge clk);
    exp_q = '{32'h0005_0007, 32'h0045_0008, 32'h0085_0009};
    chk_entries("ar_entry");

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
